char_stream_reader: RTL and testbench

//  Parametrised char-stream source. Streams a NUL-terminated string from an internal,
//  run-time loadable char memory into the HTML parser. Replaces the fixed test stream.

---
 rtl/char_stream_reader.sv | 133 +++++++++++++
 tb/tb_char_stream_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_stream_reader.sv
// -----------------------------------------------------------------------------
// char_stream_reader
//
// Streams a NUL-terminated string out of a small run-time loadable char memory
// to a downstream consumer (the tokenizer). The page loader fills the memory
// through the load_* port. A run starts at the address given on `argument` and
// produces one char every two cycles (FETCH + EMIT). The run ends after the NUL
// terminator is accepted, or after the last memory entry is accepted.
//
// Handshake: `char` is offered while char_valid=1 and is held stable until the
// consumer raises char_ready. A char counts as transferred only on a clock edge
// where char_valid=1, char_ready=1 and state_enable=1 are all present.
//
// Ports
//   clock, reset   single clock; synchronous active-high reset
//   state_enable   1 = run the stream; 0 = abort and return to IDLE
//   argument       start address, latched on IDLE->FETCH (low ADDR_WIDTH bits)
//   load_en/_addr/_data  char memory write port, honoured in every state
//   char_ready     consumer accepts the offered char this cycle
//   char           current char
//   char_valid     char is valid
//   has_finished   stream complete; held until state_enable drops
//   char_count     chars accepted this run, including the terminating NUL
//   state_dbg      FSM state (0 IDLE, 1 FETCH, 2 EMIT, 3 DONE)
// -----------------------------------------------------------------------------
module char_stream_reader #(
  parameter int CHAR_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  state_enable,
  input  logic [7:0]            argument,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [CHAR_WIDTH-1:0] load_data,
  input  logic                  char_ready,
  output logic [CHAR_WIDTH-1:0] char,
  output logic                  char_valid,
  output logic                  has_finished,
  output logic [ADDR_WIDTH:0]   char_count,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CHAR_WIDTH-1:0] char_q;
  logic                  valid_q;
  logic                  fin_q;
  logic [ADDR_WIDTH:0]   count_q;

  // Char memory. No reset: contents survive reset so a page stays loaded.
  logic [CHAR_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Only the low ADDR_WIDTH bits of argument select the start address.
  logic unused_argument;
  assign unused_argument = ^argument;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
      count_q <= '0;
    end else if (state_q != IDLE && !state_enable) begin
      // Abort wins over everything, including an EMIT handshake in the same
      // cycle. char_count is left alone so the last run's total stays visible.
      state_q <= IDLE;
      char_q  <= '0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (state_enable) begin
            addr_q  <= argument[ADDR_WIDTH-1:0];
            count_q <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          // Read-first: a write to addr_q in this same cycle is not seen here.
          char_q  <= mem_q[addr_q];
          valid_q <= 1'b1;
          state_q <= EMIT;
        end
        EMIT: begin
          if (char_ready) begin
            count_q <= count_q + 1'b1;
            valid_q <= 1'b0;
            // The stream ends on NUL, or on the last entry without wrapping.
            if (char_q == '0 || addr_q == LAST_ADDR) begin
              fin_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          // Hold everything until state_enable drops.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char         = char_q;
  assign char_valid   = valid_q;
  assign has_finished = fin_q;
  assign char_count   = count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_char_stream_reader.sv
module tb_char_stream_reader;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       state_enable;
  logic [7:0] argument;
  logic       load_en;
  logic [5:0] load_addr;
  logic [7:0] load_data;
  logic       char_ready;

  // Main instance (DEPTH=64)
  logic [7:0] m_char;
  logic       m_valid, m_fin;
  logic [6:0] m_count;
  logic [1:0] m_state;

  // Small instance (DEPTH=8) for the no-NUL end-of-memory case
  logic [7:0] s_char;
  logic       s_valid, s_fin;
  logic [3:0] s_count;
  logic [1:0] s_state;

  char_stream_reader #(.CHAR_WIDTH(8), .DEPTH(64), .ADDR_WIDTH(6)) dut (
    .clock(clock), .reset(reset), .state_enable(state_enable), .argument(argument),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .char_ready(char_ready), .char(m_char), .char_valid(m_valid),
    .has_finished(m_fin), .char_count(m_count), .state_dbg(m_state)
  );

  char_stream_reader #(.CHAR_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut_small (
    .clock(clock), .reset(reset), .state_enable(state_enable), .argument(argument),
    .load_en(load_en), .load_addr(load_addr[2:0]), .load_data(load_data),
    .char_ready(char_ready), .char(s_char), .char_valid(s_valid),
    .has_finished(s_fin), .char_count(s_count), .state_dbg(s_state)
  );

  // Observed outputs of the instance under test (sel=1 selects the small one)
  bit         sel;
  logic [7:0] obs_char;
  logic       obs_valid, obs_fin;
  logic [6:0] obs_count;
  logic [1:0] obs_state;

  always_comb begin
    obs_char  = sel ? s_char  : m_char;
    obs_valid = sel ? s_valid : m_valid;
    obs_fin   = sel ? s_fin   : m_fin;
    obs_count = sel ? {3'b000, s_count} : m_count;
    obs_state = sel ? s_state : m_state;
  end

  // ---------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_exp(input string s, input bit nul);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (nul) exp_q.push_back(8'h00);
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic load_str(input int base, input string s, input bit nul);
    for (int i = 0; i < s.len() + (nul ? 1 : 0); i++) begin
      @(negedge clock);
      load_en   = 1'b1;
      load_addr = 6'(base + i);
      load_data = (i < s.len()) ? s[i] : 8'h00;
    end
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // Runs one stream from `arg`, checking every accepted char against exp_q.
  // With stall_h set, char_ready is held low for 5 cycles when 'h' is offered.
  task automatic run_stream(input logic [7:0] arg, input bit stall_h, output int fin_cycle);
    int         cyc;
    bit         stalled;
    logic [7:0] hold_c;
    logic [6:0] hold_n;
    argument     = arg;
    state_enable = 1'b1;
    char_ready   = 1'b1;
    cyc       = 0;
    fin_cycle = -1;
    stalled   = 0;
    while (cyc < 300 && fin_cycle < 0) begin
      @(posedge clock); cyc++;
      @(negedge clock);
      if (obs_fin) begin
        fin_cycle = cyc;
      end else if (obs_valid) begin
        if (stall_h && !stalled && obs_char == 8'h68) begin
          stalled    = 1;
          char_ready = 1'b0;
          hold_c     = obs_char;
          hold_n     = obs_count;
          for (int s = 0; s < 5; s++) begin
            @(posedge clock); cyc++;
            @(negedge clock);
            check("stall_valid", 32'(obs_valid), 32'd1);
            check("stall_char",  32'(obs_char),  32'(hold_c));
            check("stall_count", 32'(obs_count), 32'(hold_n));
          end
          char_ready = 1'b1;
        end
        // Offered with ready high: accepted on the next edge.
        if (exp_q.size() == 0) check("extra_char", 32'(obs_char), 32'hFFFF_FFFF);
        else                   check("char", 32'(obs_char), 32'(exp_q.pop_front()));
      end
    end
    if (fin_cycle < 0) check("finish_timeout", 32'd0, 32'd1);
    check("chars_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Drops state_enable and checks the return to IDLE with count held.
  task automatic stop_stream(input int count_exp);
    state_enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("stop_fin",   32'(obs_fin),   32'd0);
    check("stop_valid", 32'(obs_valid), 32'd0);
    check("stop_char",  32'(obs_char),  32'd0);
    check("stop_state", 32'(obs_state), 32'd0);
    check("stop_count", 32'(obs_count), 32'(count_exp));
  endtask

  task automatic run_and_check(input logic [7:0] arg, input bit stall_h,
                               input int count_exp, input int fin_exp);
    int fin;
    run_stream(arg, stall_h, fin);
    check("fin_cycle", 32'(fin), 32'(fin_exp));
    check("fin_state", 32'(obs_state), 32'd3);
    check("count",     32'(obs_count), 32'(count_exp));
    stop_stream(count_exp);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int got;
    sel          = 0;
    reset        = 1'b1;
    state_enable = 1'b0;
    argument     = 8'd0;
    load_en      = 1'b0;
    load_addr    = 6'd0;
    load_data    = 8'd0;
    char_ready   = 1'b0;

    // Memory is written while reset is still held.
    load_str(0, "<p>hi</p>", 1);
    @(negedge clock);
    check("rst_char",  32'(obs_char),  32'd0);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_fin",   32'(obs_fin),   32'd0);
    check("rst_count", 32'(obs_count), 32'd0);
    check("rst_state", 32'(obs_state), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: full string from 0, 10 chars, done 21 cycles after enable sampled
    push_exp("<p>hi</p>", 1);
    run_and_check(8'd0, 0, 10, 21);

    // 2: start at 3 -> "hi</p>" + NUL
    push_exp("hi</p>", 1);
    run_and_check(8'd3, 0, 7, 15);

    // 3: backpressure on 'h' for 5 cycles
    push_exp("<p>hi</p>", 1);
    run_and_check(8'd0, 1, 10, 26);

    // 5: abort after the 2nd char
    argument = 8'd0; state_enable = 1'b1; char_ready = 1'b1; got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(posedge clock); @(negedge clock);
      if (obs_valid) got++;
    end
    check("abort_second_char", 32'(obs_char), 32'h70);
    @(posedge clock); @(negedge clock);
    check("abort_pre_count", 32'(obs_count), 32'd2);
    state_enable = 1'b0;
    @(posedge clock); @(negedge clock);
    check("abort_char",  32'(obs_char),  32'd0);
    check("abort_valid", 32'(obs_valid), 32'd0);
    check("abort_fin",   32'(obs_fin),   32'd0);
    check("abort_state", 32'(obs_state), 32'd0);
    check("abort_count", 32'(obs_count), 32'd2);

    // Abort in the same cycle as a handshake: the char is not counted.
    state_enable = 1'b1;
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    check("race_valid", 32'(obs_valid), 32'd1);
    state_enable = 1'b0;
    @(posedge clock); @(negedge clock);
    check("race_count", 32'(obs_count), 32'd0);
    check("race_state", 32'(obs_state), 32'd0);

    push_exp("<p>hi</p>", 1);
    run_and_check(8'd0, 0, 10, 21);

    // 6: reset mid-EMIT (with state_enable still high)
    argument = 8'd0; state_enable = 1'b1; char_ready = 1'b1;
    repeat (4) begin @(posedge clock); @(negedge clock); end
    check("pre_rst_valid", 32'(obs_valid), 32'd1);
    check("pre_rst_count", 32'(obs_count), 32'd1);
    check("pre_rst_char",  32'(obs_char),  32'h70);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("mid_rst_char",  32'(obs_char),  32'd0);
    check("mid_rst_valid", 32'(obs_valid), 32'd0);
    check("mid_rst_count", 32'(obs_count), 32'd0);
    check("mid_rst_state", 32'(obs_state), 32'd0);
    reset = 1'b0; state_enable = 1'b0;
    @(posedge clock); @(negedge clock);
    push_exp("<p>hi</p>", 1);
    run_and_check(8'd0, 0, 10, 21);

    // 6: write mem[0] while it is being fetched -> old data emitted
    argument = 8'd0; state_enable = 1'b1;
    @(posedge clock); @(negedge clock);
    check("wr_fetch_state", 32'(obs_state), 32'd1);
    load_en = 1'b1; load_addr = 6'd0; load_data = 8'h58;
    @(posedge clock); @(negedge clock);
    load_en = 1'b0;
    check("wr_old_char",  32'(obs_char),  32'h3C);
    check("wr_old_valid", 32'(obs_valid), 32'd1);
    stop_stream(0);
    push_exp("Xp>hi</p>", 1);
    run_and_check(8'd0, 0, 10, 21);

    // 4: DEPTH=8, no NUL, start at 5 -> "fgh"
    sel = 1;
    load_str(0, "abcdefgh", 0);
    push_exp("fgh", 0);
    run_and_check(8'd5, 0, 3, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
